// File: rtl/conv_mem_arbiter_if.sv
// Requester-side bus of the conv memory arbiter: per-requester request
// handshake plus the shared read-response return path.
interface conv_mem_arbiter_if #(
  parameter int NREQ = 4,
  parameter int AW   = 8,
  parameter int DW   = 32
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_we;
  logic [NREQ-1:0]    req_lock;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_rdata;

  // Conv controllers drive requests and consume grants/responses.
  modport master (
    output req_valid, req_we, req_lock, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  // The arbiter consumes requests and produces grants/responses.
  modport slave (
    input  req_valid, req_we, req_lock, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/conv_mem_arbiter.sv
// conv_mem_arbiter: round-robin arbiter sharing one single-port conv data
// memory among NREQ controllers. One access accepted per cycle; the memory
// command is registered (accept + 1) and read data returns to the winning
// requester at accept + 2, tagged by a pipelined requester id.
// Optional burst lock is enabled by defining CONV_ARB_LOCK_EN.
module conv_mem_arbiter #(
  parameter int NREQ     = 4,
  parameter int AW       = 8,
  parameter int DW       = 32,
  parameter int MAX_HOLD = 16
) (
  input  logic                clock,
  input  logic                reset,
  conv_mem_arbiter_if.slave   bus,
  output logic                mem_en,
  output logic                mem_we,
  output logic [AW-1:0]       mem_addr,
  output logic [DW-1:0]       mem_wdata,
  input  logic [DW-1:0]       mem_rdata
);

  localparam int IDW = $clog2(NREQ);

  typedef enum logic {ARB, LOCKED} state_t;

  state_t          state, state_next;
  logic [IDW-1:0]  rr_ptr, rr_next;
  logic [IDW-1:0]  winner;
  logic [IDW-1:0]  grant_id;
  logic            found;
  logic            accept;
  logic [NREQ-1:0] ready;
  logic [IDW-1:0]  mem_id;
  logic [NREQ-1:0] rsp_valid_q;

  // Successor of a requester id in circular order.
  function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
    if (id == IDW'(NREQ - 1)) return '0;
    return id + 1'b1;
  endfunction

  // Round-robin search: first valid requester starting at rr_ptr.
  always_comb begin
    int idx;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && bus.req_valid[IDW'(idx)]) begin
        found  = 1'b1;
        winner = IDW'(idx);
      end
    end
  end

`ifdef CONV_ARB_LOCK_EN
  logic [IDW-1:0] owner, owner_next;
  logic [7:0]     hold_cnt, hold_next;

  // Grant selection and next-state logic with burst lock.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path can
    // leave it unassigned and infer a latch.
    ready      = '0;
    grant_id   = winner;
    state_next = state;
    rr_next    = rr_ptr;
    owner_next = owner;
    hold_next  = hold_cnt;
    case (state)
      ARB: begin
        if (found) begin
          ready[winner] = 1'b1;
          rr_next       = next_id(winner);
          if (bus.req_lock[winner] && (MAX_HOLD > 1)) begin
            state_next = LOCKED;
            owner_next = winner;
            hold_next  = 8'd1;
          end
        end
      end
      LOCKED: begin
        grant_id = owner;
        if (bus.req_valid[owner]) begin
          ready[owner] = 1'b1;
          // The accept that reaches MAX_HOLD is still taken, then we release.
          if (!bus.req_lock[owner] || (hold_cnt >= 8'(MAX_HOLD - 1))) begin
            state_next = ARB;
            hold_next  = '0;
            rr_next    = next_id(owner);
          end else begin
            hold_next = hold_cnt + 8'd1;
          end
        end else begin
          state_next = ARB;
          hold_next  = '0;
          rr_next    = next_id(owner);
        end
      end
      default: state_next = ARB;
    endcase
  end

  // Lock owner and burst length registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      owner    <= '0;
      hold_cnt <= '0;
    end else begin
      owner    <= owner_next;
      hold_cnt <= hold_next;
    end
  end
`else
  // Without the lock feature the burst-lock request is ignored.
  logic unused_lock;
  assign unused_lock = ^{bus.req_lock, 8'(MAX_HOLD)};

  // Plain round-robin grant; every accept rotates the pointer.
  always_comb begin
    ready      = '0;
    grant_id   = winner;
    state_next = state;
    rr_next    = rr_ptr;
    if (found) begin
      ready[winner] = 1'b1;
      rr_next       = next_id(winner);
    end
  end
`endif

  assign accept        = |ready;
  assign bus.req_ready = ready;

  // Arbitration state and round-robin pointer.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state  <= ARB;
      rr_ptr <= '0;
    end else begin
      state  <= state_next;
      rr_ptr <= rr_next;
    end
  end

  // Memory command stage: register the granted access and its requester id.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_id    <= '0;
    end else begin
      mem_en <= accept;
      mem_we <= accept & bus.req_we[grant_id];
      if (accept) begin
        mem_addr  <= bus.req_addr[grant_id*AW +: AW];
        mem_wdata <= bus.req_wdata[grant_id*DW +: DW];
        mem_id    <= grant_id;
      end
    end
  end

  // Response stage: strobe the requester whose read was issued last cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rsp_valid_q <= '0;
    end else if (mem_en && !mem_we) begin
      rsp_valid_q <= NREQ'(1) << mem_id;
    end else begin
      rsp_valid_q <= '0;
    end
  end

  // Memory read data arrives in the response cycle; zero it otherwise.
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = (|rsp_valid_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_conv_mem_arbiter.sv
// Self-checking bench for conv_mem_arbiter: directed scenarios plus random
// traffic, compared cycle by cycle against a behavioural model of the
// arbitration rules and an in-order reference memory.
module tb_conv_mem_arbiter;
  localparam int NREQ     = 4;
  localparam int AW       = 8;
  localparam int DW       = 32;
  localparam int MAX_HOLD = 4;

  typedef struct packed {
    logic [NREQ-1:0] ready;
    logic            en;
    logic            we;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   wdata;
    logic [NREQ-1:0] rsp;
    logic [DW-1:0]   rdata;
  } snap_t;

  logic          clock = 1'b0;
  logic          reset;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  conv_mem_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  conv_mem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
    .clock(clock), .reset(reset), .bus(bus),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  function automatic logic [DW-1:0] init_word(input int a);
    return (32'(a) * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  // Synchronous single-port memory, one cycle read latency.
  logic [DW-1:0] ram [256];
  bit            ram_vld [256];
  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr]     <= mem_wdata;
        ram_vld[mem_addr] <= 1'b1;
      end else begin
        mem_rdata <= ram_vld[mem_addr] ? ram[mem_addr] : init_word(int'(mem_addr));
      end
    end
  end

  // Requester drivers.
  int            rem     [NREQ];
  bit            d_we    [NREQ];
  bit            d_lock  [NREQ];
  logic [AW-1:0] d_addr  [NREQ];
  logic [DW-1:0] d_wdata [NREQ];

  // Reference model state.
  logic [DW-1:0]   ref_mem [256];
  int              m_rr, m_owner, m_hold;
  bit              m_locked;
  bit              s1_en, s1_we;
  logic [AW-1:0]   s1_addr;
  logic [DW-1:0]   s1_wdata, s1_rdata;
  int              s1_id;
  logic [NREQ-1:0] s2_rsp;
  logic [DW-1:0]   s2_data;

  snap_t obs, exp;
  int    cyc;
  int    checks = 0;
  int    errors = 0;

  task automatic drive();
    for (int n = 0; n < NREQ; n++) begin
      bus.req_valid[n]          = (rem[n] > 0);
      bus.req_we[n]             = d_we[n];
      bus.req_lock[n]           = d_lock[n];
      bus.req_addr[n*AW +: AW]  = d_addr[n];
      bus.req_wdata[n*DW +: DW] = d_wdata[n];
    end
  endtask

  task automatic set_req(input int n, input int count, input bit we, input bit lock,
                         input logic [AW-1:0] a, input logic [DW-1:0] wd);
    rem[n] = count; d_we[n] = we; d_lock[n] = lock; d_addr[n] = a; d_wdata[n] = wd;
  endtask

  task automatic model_reset();
    m_rr = 0; m_owner = 0; m_hold = 0; m_locked = 1'b0;
    s1_en = 1'b0; s1_we = 1'b0; s1_addr = '0; s1_wdata = '0; s1_rdata = '0; s1_id = 0;
    s2_rsp = '0; s2_data = '0;
    for (int n = 0; n < NREQ; n++) rem[n] = 0;
  endtask

  // Which requester the rules say is granted this cycle (-1: none).
  function automatic int predict();
`ifdef CONV_ARB_LOCK_EN
    if (m_locked) return (rem[m_owner] > 0) ? m_owner : -1;
`endif
    for (int k = 0; k < NREQ; k++)
      if (rem[(m_rr + k) % NREQ] > 0) return (m_rr + k) % NREQ;
    return -1;
  endfunction

  function automatic snap_t sample();
    snap_t s;
    s.ready = bus.req_ready; s.en = mem_en; s.we = mem_we; s.addr = mem_addr;
    s.wdata = mem_wdata; s.rsp = bus.rsp_valid; s.rdata = bus.rsp_rdata;
    return s;
  endfunction

  function automatic int onehot_idx(input logic [NREQ-1:0] v);
    if ($countones(v) != 1) return -1;
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  // One clock cycle: sample mid-cycle, then advance model and drivers.
  task automatic tick();
    int g;
    drive();
    @(negedge clock);
    g = predict();
    exp.ready = (g >= 0) ? (NREQ'(1) << g) : '0;
    exp.en = s1_en; exp.we = s1_we; exp.addr = s1_addr; exp.wdata = s1_wdata;
    exp.rsp = s2_rsp; exp.rdata = s2_data;
    obs = sample();
    @(posedge clock);
    s2_rsp  = (s1_en && !s1_we) ? (NREQ'(1) << s1_id) : '0;
    s2_data = (s1_en && !s1_we) ? s1_rdata : '0;
    if (g >= 0) begin
      s1_en = 1'b1; s1_we = d_we[g]; s1_addr = d_addr[g]; s1_wdata = d_wdata[g]; s1_id = g;
      s1_rdata = ref_mem[d_addr[g]];
      if (d_we[g]) ref_mem[d_addr[g]] = d_wdata[g];
    end else begin
      s1_en = 1'b0; s1_we = 1'b0;
    end
`ifdef CONV_ARB_LOCK_EN
    if (m_locked) begin
      if (g < 0) begin
        m_locked = 1'b0; m_rr = (m_owner + 1) % NREQ;
      end else begin
        m_hold++;
        if (!d_lock[g] || m_hold >= MAX_HOLD) begin
          m_locked = 1'b0; m_rr = (g + 1) % NREQ;
        end
      end
    end else if (g >= 0) begin
      m_rr = (g + 1) % NREQ;
      if (d_lock[g]) begin
        m_hold = 1;
        if (MAX_HOLD > 1) begin m_locked = 1'b1; m_owner = g; end
      end
    end
`else
    if (g >= 0) m_rr = (g + 1) % NREQ;
`endif
    if (g >= 0) rem[g]--;
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    drive();
    repeat (2) @(negedge clock);
    obs = sample();
    checks++;
    if (obs !== '0) begin
      errors++; $display("FAIL reset_values: got %h want 0", obs);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (2) begin
      tick(); checks++;
      if (obs !== exp) begin errors++; $display("FAIL reset_idle cyc %0d: got %h want %h", cyc, obs, exp); end
    end
  endtask

  task automatic test_rr_reads();
    for (int n = 0; n < NREQ; n++) set_req(n, 1, 1'b0, 1'b0, AW'(8'h10 + n), $urandom);
    for (int k = 0; k < 8; k++) begin
      tick(); checks++;
      if (obs !== exp) begin errors++; $display("FAIL rr_reads cyc %0d: got %h want %h", cyc, obs, exp); end
      if (k < 4) begin
        checks++;
        if (obs.ready !== (NREQ'(1) << k)) begin
          errors++; $display("FAIL rr_order k=%0d: got %b want %b", k, obs.ready, NREQ'(1) << k);
        end
      end
      if (k >= 2 && k < 6) begin
        checks++;
        if (obs.rsp !== (NREQ'(1) << (k - 2)) || obs.rdata !== ref_mem[8'h10 + k - 2]) begin
          errors++; $display("FAIL rr_rsp k=%0d: got %b/%h want %b/%h", k, obs.rsp, obs.rdata,
                             NREQ'(1) << (k - 2), ref_mem[8'h10 + k - 2]);
        end
      end
    end
  endtask

  task automatic test_write_then_read();
    bit            seen = 1'b0;
    logic [DW-1:0] got = '0;
    set_req(2, 1, 1'b1, 1'b0, 8'h40, 32'hDEAD_BEEF);
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k == 0) set_req(1, 1, 1'b0, 1'b0, 8'h40, $urandom);
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL wr_rd cyc %0d: got %h want %h", cyc, obs, exp); end
      if (obs.rsp[1]) begin seen = 1'b1; got = obs.rdata; end
    end
    checks++;
    if (!seen || got !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL wr_rd_data: got seen=%0b %h want seen=1 deadbeef", seen, got);
    end
  endtask

  task automatic test_single_wrap();
    set_req(3, 5, 1'b0, 1'b0, 8'h20, $urandom);
    for (int k = 0; k < 5; k++) begin
      tick(); checks++;
      if (obs.ready !== 4'b1000 || obs !== exp) begin
        errors++; $display("FAIL single_req cyc %0d: got %h want %h", cyc, obs, exp);
      end
    end
    set_req(0, 1, 1'b0, 1'b0, 8'h21, $urandom);
    set_req(3, 1, 1'b0, 1'b0, 8'h22, $urandom);
    tick(); checks++;
    if (obs.ready !== 4'b0001) begin
      errors++; $display("FAIL wrap_winner: got %b want 0001", obs.ready);
    end
    repeat (4) begin
      tick(); checks++;
      if (obs !== exp) begin errors++; $display("FAIL wrap_drain cyc %0d: got %h want %h", cyc, obs, exp); end
    end
  endtask

  task automatic test_reset_mid();
    int rsp_seen = 0;
    set_req(0, 1, 1'b0, 1'b0, 8'h10, $urandom);
    tick(); checks++;
    if (obs.ready !== 4'b0001) begin errors++; $display("FAIL mid_accept: got %b want 0001", obs.ready); end
    reset = 1'b1;
    model_reset();
    drive();
    @(negedge clock);
    obs = sample(); checks++;
    if (obs !== '0) begin errors++; $display("FAIL mid_reset_outputs: got %h want 0", obs); end
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (4) begin
      tick(); checks++;
      if (obs !== exp) begin errors++; $display("FAIL mid_after cyc %0d: got %h want %h", cyc, obs, exp); end
      if (obs.rsp !== '0) rsp_seen++;
    end
    checks++;
    if (rsp_seen != 0) begin errors++; $display("FAIL mid_dropped: got %0d rsp want 0", rsp_seen); end
  endtask

  task automatic test_lock();
    int exp_order [6];
    int nexp;
    int g;
`ifdef CONV_ARB_LOCK_EN
    exp_order = '{1, 1, 1, 1, 2, 0}; nexp = 6;
`else
    exp_order = '{1, 2, 0, 0, 0, 0}; nexp = 3;
`endif
    set_req(0, 1, 1'b0, 1'b0, 8'h30, $urandom);
    tick();
    set_req(1, 100, 1'b0, 1'b1, 8'h31, $urandom);
    set_req(0, 1, 1'b1, 1'b0, 8'h32, $urandom);
    set_req(2, 1, 1'b0, 1'b0, 8'h33, $urandom);
    for (int k = 0; k < nexp; k++) begin
      tick();
      g = onehot_idx(obs.ready);
      checks++;
      if (g != exp_order[k] || obs !== exp) begin
        errors++; $display("FAIL lock_order k=%0d: got %0d (%h) want %0d (%h)", k, g, obs, exp_order[k], exp);
      end
    end
    rem[1] = 0; d_lock[1] = 1'b0;
    repeat (4) begin
      tick(); checks++;
      if (obs !== exp) begin errors++; $display("FAIL lock_drain cyc %0d: got %h want %h", cyc, obs, exp); end
    end
  endtask

  task automatic test_idle();
    for (int k = 0; k < 10; k++) begin
      tick(); checks++;
      if (obs !== exp || obs.en !== 1'b0) begin
        errors++; $display("FAIL idle cyc %0d: got %h want %h", cyc, obs, exp);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      for (int n = 0; n < NREQ; n++)
        if (rem[n] == 0 && $urandom_range(0, 2) == 0)
          set_req(n, $urandom_range(1, 3), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                  AW'(8'h50 + $urandom_range(0, 7)), $urandom);
      tick(); checks++;
      if (obs !== exp) begin errors++; $display("FAIL random cyc %0d: got %h want %h", cyc, obs, exp); end
    end
    for (int n = 0; n < NREQ; n++) rem[n] = 0;
    repeat (4) begin
      tick(); checks++;
      if (obs !== exp) begin errors++; $display("FAIL random_drain cyc %0d: got %h want %h", cyc, obs, exp); end
    end
  endtask

  initial begin
    reset = 1'b1;
    cyc   = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    for (int n = 0; n < NREQ; n++) begin
      d_we[n] = 1'b0; d_lock[n] = 1'b0; d_addr[n] = '0; d_wdata[n] = '0;
    end
    test_reset();
    test_rr_reads();
    test_write_then_read();
    test_single_wrap();
    test_reset_mid();
    test_lock();
    test_idle();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
